// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, multdiv and
// exception writers are round-robined, and starvation raises a writeback stall.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        ctrl_reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_reg,
    input  logic [31:0] md_data,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_reg,
    input  logic [31:0] ex_data,
    output logic        stall_req,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic        wb_violation
);

    localparam logic ST_RUN   = 1'b0;
    localparam logic ST_STALL = 1'b1;
    localparam logic RR_MD    = 1'b0;
    localparam logic RR_EX    = 1'b1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic             state, state_nxt;
    logic             rr_ptr;
    logic [CNT_W-1:0] md_cnt, ex_cnt, md_cnt_nxt, ex_cnt_nxt;
    logic             md_grant, ex_grant, md_xfer, ex_xfer;
    logic             any_starved;
    logic             sel_en;
    logic [4:0]       sel_reg;
    logic [31:0]      sel_data;

    always_comb begin
        md_grant = 1'b0;
        ex_grant = 1'b0;
        if (!ctrl_reset && !wb_valid) begin
            if (md_valid && !ex_valid)       md_grant = 1'b1;
            else if (ex_valid && !md_valid)  ex_grant = 1'b1;
            else if (md_valid && ex_valid) begin
                if (rr_ptr == RR_MD) md_grant = 1'b1;
                else                 ex_grant = 1'b1;
            end
        end
    end

    assign md_ready = md_grant;
    assign ex_ready = ex_grant;
    assign md_xfer  = md_valid && md_grant;
    assign ex_xfer  = ex_valid && ex_grant;

    // Counters clear on transfer or withdrawn request, otherwise saturate at LIMIT.
    always_comb begin
        md_cnt_nxt = '0;
        ex_cnt_nxt = '0;
        if (md_valid && !md_xfer)
            md_cnt_nxt = (md_cnt == LIMIT) ? md_cnt : md_cnt + 1'b1;
        if (ex_valid && !ex_xfer)
            ex_cnt_nxt = (ex_cnt == LIMIT) ? ex_cnt : ex_cnt + 1'b1;
        any_starved = (md_cnt_nxt == LIMIT) || (ex_cnt_nxt == LIMIT);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (any_starved)  state_nxt = ST_STALL;
            ST_STALL: if (!any_starved) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        sel_en   = 1'b0;
        sel_reg  = ctrl_writeReg;
        sel_data = data_writeReg;
        if (wb_valid) begin
            sel_en   = 1'b1;
            sel_reg  = wb_reg;
            sel_data = wb_data;
        end else if (md_xfer) begin
            sel_en   = 1'b1;
            sel_reg  = md_reg;
            sel_data = md_data;
        end else if (ex_xfer) begin
            sel_en   = 1'b1;
            sel_reg  = ex_reg;
            sel_data = ex_data;
        end
    end

    always_ff @(posedge clk) begin
        if (ctrl_reset) begin
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= '0;
            data_writeReg    <= '0;
            wb_violation     <= 1'b0;
            md_cnt           <= '0;
            ex_cnt           <= '0;
            rr_ptr           <= RR_MD;
            state            <= ST_RUN;
        end else begin
            ctrl_writeEnable <= sel_en && (sel_reg != 5'd0);
            ctrl_writeReg    <= sel_reg;
            data_writeReg    <= sel_data;
            md_cnt           <= md_cnt_nxt;
            ex_cnt           <= ex_cnt_nxt;
            state            <= state_nxt;
            if (state == ST_STALL && wb_valid) wb_violation <= 1'b1;
            if (md_xfer)      rr_ptr <= RR_EX;
            else if (ex_xfer) rr_ptr <= RR_MD;
        end
    end

    assign stall_req = (state == ST_STALL);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: stimulus queues expected regfile writes, a monitor checks them.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        ctrl_reset;
    logic        wb_valid, md_valid, ex_valid;
    logic [4:0]  wb_reg, md_reg, ex_reg;
    logic [31:0] wb_data, md_data, ex_data;
    logic        md_ready, ex_ready, stall_req;
    logic        ctrl_writeEnable, wb_violation;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;

    int checks = 0;
    int passes = 0;
    logic [36:0] exp_q[$];
    logic        mon_on = 1'b1;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .ctrl_reset(ctrl_reset),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .md_valid(md_valid), .md_ready(md_ready), .md_reg(md_reg), .md_data(md_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_reg(ex_reg), .ex_data(ex_data),
        .stall_req(stall_req), .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .wb_violation(wb_violation)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic expect_write(input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back({r, d});
    endtask

    // Inputs change 1 time unit after each rising edge; combinational grants settle by +2.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #2;
        if (mon_on && ctrl_writeEnable) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {27'd0, ctrl_writeReg}, 32'hFFFF_FFFF);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("write_reg", {27'd0, ctrl_writeReg}, {27'd0, e[36:32]});
                chk("write_data", data_writeReg, e[31:0]);
            end
        end
    end

    initial begin
        ctrl_reset = 1'b1;
        wb_valid = 1'b1; md_valid = 1'b1; ex_valid = 1'b1;
        wb_reg = 5'd1; wb_data = 32'h1111_1111;
        md_reg = 5'd2; md_data = 32'h2222_2222;
        ex_reg = 5'd3; ex_data = 32'h3333_3333;
        repeat (3) next_cycle();
        #1;
        chk("rst_md_ready", {31'd0, md_ready}, 32'd0);
        chk("rst_ex_ready", {31'd0, ex_ready}, 32'd0);
        chk("rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
        chk("rst_reg", {27'd0, ctrl_writeReg}, 32'd0);
        chk("rst_data", data_writeReg, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_viol", {31'd0, wb_violation}, 32'd0);

        // Round-robin: MD, EX, MD, EX with both sources requesting.
        next_cycle();
        ctrl_reset = 1'b0; wb_valid = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            md_reg = 5'd7;  md_data = 32'hA000_0000 + i;
            ex_reg = 5'd8;  ex_data = 32'hB000_0000 + i;
            #1;
            if (i % 2 == 0) begin
                chk("rr_md_ready", {31'd0, md_ready}, 32'd1);
                chk("rr_ex_ready", {31'd0, ex_ready}, 32'd0);
                expect_write(5'd7, 32'hA000_0000 + i);
            end else begin
                chk("rr_md_ready", {31'd0, md_ready}, 32'd0);
                chk("rr_ex_ready", {31'd0, ex_ready}, 32'd1);
                expect_write(5'd8, 32'hB000_0000 + i);
            end
            next_cycle();
        end

        // Writeback preempts a valid multdiv result.
        ex_valid = 1'b0;
        wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'hDEAD_BEEF;
        #1;
        chk("wb_md_ready", {31'd0, md_ready}, 32'd0);
        expect_write(5'd5, 32'hDEAD_BEEF);
        next_cycle();
        wb_valid = 1'b0; md_valid = 1'b0;
        next_cycle();

        // Exception starves behind writeback for STARVE_LIMIT cycles.
        ex_valid = 1'b1; ex_reg = 5'd30; ex_data = 32'h3030_3030;
        for (int unsigned i = 0; i < 4; i++) begin
            wb_valid = 1'b1; wb_reg = 5'd9; wb_data = 32'hC000_0000 + i;
            #1;
            chk("starve_ex_ready", {31'd0, ex_ready}, 32'd0);
            chk("starve_stall_low", {31'd0, stall_req}, 32'd0);
            expect_write(5'd9, 32'hC000_0000 + i);
            next_cycle();
        end
        wb_valid = 1'b0;
        #1;
        chk("stall_high", {31'd0, stall_req}, 32'd1);
        chk("stall_ex_ready", {31'd0, ex_ready}, 32'd1);
        expect_write(5'd30, 32'h3030_3030);
        next_cycle();
        ex_valid = 1'b0;
        #1;
        chk("stall_released", {31'd0, stall_req}, 32'd0);
        chk("no_violation", {31'd0, wb_violation}, 32'd0);
        next_cycle();

        // Write to r0 handshakes but does not enable the regfile.
        md_valid = 1'b1; md_reg = 5'd0; md_data = 32'h0000_1234;
        #1;
        chk("r0_md_ready", {31'd0, md_ready}, 32'd1);
        next_cycle();
        md_valid = 1'b0;
        #1;
        chk("r0_we_low", {31'd0, ctrl_writeEnable}, 32'd0);
        next_cycle();

        // Writeback held during STALL sets the sticky violation flag.
        md_valid = 1'b1; md_reg = 5'd12; md_data = 32'h5555_AAAA;
        for (int unsigned i = 0; i < 5; i++) begin
            wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'hD000_0000 + i;
            #1;
            chk("viol_md_ready", {31'd0, md_ready}, 32'd0);
            chk("viol_stall", {31'd0, stall_req}, (i == 4) ? 32'd1 : 32'd0);
            chk("viol_pre", {31'd0, wb_violation}, 32'd0);
            expect_write(5'd3, 32'hD000_0000 + i);
            next_cycle();
        end
        wb_valid = 1'b0;
        #1;
        chk("viol_set", {31'd0, wb_violation}, 32'd1);
        chk("viol_still_stall", {31'd0, stall_req}, 32'd1);
        chk("viol_md_grant", {31'd0, md_ready}, 32'd1);
        expect_write(5'd12, 32'h5555_AAAA);
        next_cycle();
        md_valid = 1'b0;
        #1;
        chk("viol_sticky", {31'd0, wb_violation}, 32'd1);
        chk("viol_run", {31'd0, stall_req}, 32'd0);
        next_cycle();

        ctrl_reset = 1'b1; md_valid = 1'b1; ex_valid = 1'b1;
        #1;
        chk("rst2_md_ready", {31'd0, md_ready}, 32'd0);
        chk("rst2_ex_ready", {31'd0, ex_ready}, 32'd0);
        next_cycle();
        #1;
        chk("rst2_viol", {31'd0, wb_violation}, 32'd0);
        chk("rst2_we", {31'd0, ctrl_writeEnable}, 32'd0);
        ctrl_reset = 1'b0; md_valid = 1'b0; ex_valid = 1'b0;
        repeat (2) next_cycle();

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
